// File: rtl/pio_edge_irq.sv
// Input-conditioning and interrupt companion for the PIO: two-flop sync, per-pin debounce,
// edge detection into a write-1-to-clear capture register, Avalon-MM slave and level irq.
module pio_edge_irq #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] filtered_out,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RISE = 3'd1;
  localparam logic [2:0] ADDR_FALL = 3'd2;
  localparam logic [2:0] ADDR_MASK = 3'd3;
  localparam logic [2:0] ADDR_CAP  = 3'd4;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic [31:0]      rd_mux;

  // pins_in is asynchronous to clk; sync1 is the only flop allowed to go metastable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_in;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic filt_bit;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            filt_bit <= 1'b0;
          end else begin
            filt_bit <= sync2[gi];
          end
        end
        assign filt[gi] = filt_bit;
      end
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic          filt_bit;
        logic [CW-1:0] cnt;
        // cnt counts consecutive cycles of disagreement; any agreement restarts it.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            filt_bit <= 1'b0;
            cnt      <= '0;
          end else if (sync2[gi] == filt_bit) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            filt_bit <= sync2[gi];
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        assign filt[gi] = filt_bit;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_d <= '0;
    end else begin
      filt_d <= filt;
    end
  end

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign rise  = filt & ~filt_d;
  assign fall  = ~filt & filt_d;
  assign set   = (rise & rise_en) | (fall & fall_en);
  assign clr   = (wr && address == ADDR_CAP) ? wdata : '0;

  // A new edge on a bit being cleared in the same cycle keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
      capture  <= '0;
    end else begin
      capture <= (capture & ~clr) | set;
      if (wr) begin
        case (address)
          ADDR_RISE: rise_en  <= wdata;
          ADDR_FALL: fall_en  <= wdata;
          ADDR_MASK: irq_mask <= wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(filt);
      ADDR_RISE: rd_mux = 32'(rise_en);
      ADDR_FALL: rd_mux = 32'(fall_en);
      ADDR_MASK: rd_mux = 32'(irq_mask);
      ADDR_CAP:  rd_mux = 32'(capture);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign filtered_out = filt;
  assign irq          = |(capture & irq_mask);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Bench for pio_edge_irq: directed latency/boundary scenarios plus a randomized run
// checked against a sliding-window reference model of the pin conditioning.
module tb_pio_edge_irq;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] pins_in;
  logic [31:0] filtered_out;
  logic        irq;

  logic [2:0]  address0;
  logic        cs0;
  logic        wn0;
  logic [31:0] wd0;
  logic [31:0] rd0;
  logic [31:0] pins0;
  logic [31:0] filt0;
  logic        irq0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pio_edge_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pins_in(pins_in), .filtered_out(filtered_out), .irq(irq)
  );

  pio_edge_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address0), .chipselect(cs0),
    .write_n(wn0), .writedata(wd0), .readdata(rd0),
    .pins_in(pins0), .filtered_out(filt0), .irq(irq0)
  );

  // Reference model: hist[i] is the pin word sampled i+1 edges ago. A bit of the filtered
  // value flips once the pin has held the opposite level for the D samples that reached
  // the debouncer (two synchroniser stages behind the pin).
  logic [31:0] hist [0:D];
  logic [31:0] m_filt, m_filt_prev, m_rise_en, m_fall_en, m_mask, m_cap;

  function automatic logic [31:0] flip_mask();
    logic [31:0] m;
    m = '1;
    for (int i = 1; i <= D; i++) m &= hist[i] ^ m_filt;
    return m;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_filt;
      3'd1:    return m_rise_en;
      3'd2:    return m_fall_en;
      3'd3:    return m_mask;
      3'd4:    return m_cap;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= D; i++) hist[i] <= '0;
      m_filt <= '0; m_filt_prev <= '0; m_rise_en <= '0;
      m_fall_en <= '0; m_mask <= '0; m_cap <= '0;
    end else begin
      hist[0] <= pins_in;
      for (int i = 1; i <= D; i++) hist[i] <= hist[i-1];
      m_filt      <= m_filt ^ flip_mask();
      m_filt_prev <= m_filt;
      m_cap <= (m_cap & ~((chipselect && !write_n && address == 3'd4) ? writedata : 32'h0))
             | (m_filt & ~m_filt_prev & m_rise_en) | (~m_filt & m_filt_prev & m_fall_en);
      if (chipselect && !write_n) begin
        if (address == 3'd1) m_rise_en <= writedata;
        if (address == 3'd2) m_fall_en <= writedata;
        if (address == 3'd3) m_mask    <= writedata;
      end
    end
  end

  // Bus helpers start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
    $display("read  addr=%0d data=%h", a, d);
  endtask

  task automatic test_reset();
    logic [31:0] v, exp_f, exp_r;
    @(negedge clk);
    reset_n = 1'b0; pins_in = '1; pins0 = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata got %h exp 0", readdata); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (filtered_out !== 32'h0) begin fails++; $display("FAIL reset_filt got %h exp 0", filtered_out); end
    address = 3'd0; reset_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      exp_f = (n >= D + 2) ? 32'hFFFF_FFFF : 32'h0;
      exp_r = (n >= D + 3) ? 32'hFFFF_FFFF : 32'h0;
      checks++; if (filtered_out !== exp_f) begin fails++; $display("FAIL hi_reset_filt edge %0d got %h exp %h", n, filtered_out, exp_f); end
      checks++; if (readdata !== exp_r) begin fails++; $display("FAIL hi_reset_rd0 edge %0d got %h exp %h", n, readdata, exp_r); end
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL hi_reset_irq edge %0d got %b exp 0", n, irq); end
    end
    for (int a = 1; a < 8; a++) begin
      bus_read(3'(a), v);
      checks++; if (v !== 32'h0) begin fails++; $display("FAIL hi_reset_reg addr %0d got %h exp 0", a, v); end
    end
  endtask

  task automatic test_no_debounce();
    logic [31:0] exp_f, exp_r;
    address0 = 3'd0; cs0 = 1'b0; wn0 = 1'b1; wd0 = '0;
    pins0 = 32'hA5A5_0000;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      exp_f = (n >= 3) ? 32'hA5A5_0000 : 32'h0;
      exp_r = (n >= 4) ? 32'hA5A5_0000 : 32'h0;
      checks++; if (filt0 !== exp_f) begin fails++; $display("FAIL d0_filt edge %0d got %h exp %h", n, filt0, exp_f); end
      checks++; if (rd0 !== exp_r) begin fails++; $display("FAIL d0_read edge %0d got %h exp %h", n, rd0, exp_r); end
    end
    for (int a = 0; a < 8; a++) begin
      if (a != 0 && a < 5) continue;
      address0 = 3'(a); wd0 = '1; cs0 = 1'b1; wn0 = 1'b0;
      @(negedge clk);
      cs0 = 1'b0; wn0 = 1'b1;
      @(negedge clk);
      exp_r = (a == 0) ? 32'hA5A5_0000 : 32'h0;
      checks++; if (rd0 !== exp_r) begin fails++; $display("FAIL d0_ro_reg addr %0d got %h exp %h", a, rd0, exp_r); end
    end
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL d0_irq got %b exp 0", irq0); end
  endtask

  task automatic test_rise_latency();
    logic exp_b;
    reset_n = 1'b0; pins_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
    bus_write(3'd1, 32'h1);
    bus_write(3'd3, 32'h1);
    address = 3'd4; pins_in = 32'h1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      exp_b = (n >= 6);
      checks++; if (filtered_out[0] !== exp_b) begin fails++; $display("FAIL rise_filt edge %0d got %b exp %b", n, filtered_out[0], exp_b); end
      exp_b = (n >= 7);
      checks++; if (irq !== exp_b) begin fails++; $display("FAIL rise_irq edge %0d got %b exp %b", n, irq, exp_b); end
      checks++; if (readdata !== ((n >= 8) ? 32'h1 : 32'h0)) begin fails++; $display("FAIL rise_cap_read edge %0d got %h", n, readdata); end
    end
  endtask

  task automatic test_clear();
    bus_write(3'd4, 32'h1);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL clear_irq got %b exp 0", irq); end
    checks++; if (readdata !== 32'h1) begin fails++; $display("FAIL clear_old_read got %h exp 1", readdata); end
    @(negedge clk);
    checks++; if (readdata !== 32'h0) begin fails++; $display("FAIL clear_new_read got %h exp 0", readdata); end
    pins_in[0] = 1'b0; repeat (8) @(negedge clk);
    pins_in[0] = 1'b1; repeat (8) @(negedge clk);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL rerise_irq got %b exp 1", irq); end
    pins_in[0] = 1'b0; repeat (8) @(negedge clk);
    pins_in[0] = 1'b1; repeat (6) @(negedge clk);
    // The clear lands on the same edge as the new capture.
    address = 3'd4; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL set_vs_clear_irq got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (readdata !== 32'h1) begin fails++; $display("FAIL set_vs_clear_cap got %h exp 1", readdata); end
    bus_write(3'd4, 32'h1);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL final_clear_irq got %b exp 0", irq); end
  endtask

  task automatic test_short_pulse();
    logic [31:0] v;
    logic        seen;
    pins_in[0] = 1'b0; repeat (8) @(negedge clk);
    pins_in[0] = 1'b1; repeat (D - 1) @(negedge clk);
    pins_in[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      seen |= filtered_out[0];
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL short_irq cycle %0d got %b exp 0", n, irq); end
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL short_filt got %b exp 0", seen); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'h0) begin fails++; $display("FAIL short_cap got %h exp 0", v); end
    pins_in[0] = 1'b1; repeat (D) @(negedge clk);
    pins_in[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      seen |= filtered_out[0];
    end
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL exact_pulse_filt got %b exp 1", seen); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'h1) begin fails++; $display("FAIL exact_pulse_cap got %h exp 1", v); end
    bus_write(3'd4, 32'h1);
  endtask

  task automatic test_fall_mask();
    logic [31:0] v;
    bus_write(3'd2, 32'h8000_0000);
    bus_write(3'd3, 32'h0);
    pins_in[31] = 1'b1; repeat (10) @(negedge clk);
    bus_read(3'd4, v);
    checks++; if (v !== 32'h0) begin fails++; $display("FAIL fall_rise_ignored got %h exp 0", v); end
    pins_in[31] = 1'b0; repeat (10) @(negedge clk);
    bus_read(3'd4, v);
    checks++; if (v !== 32'h8000_0000) begin fails++; $display("FAIL fall_cap got %h exp 80000000", v); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL fall_masked_irq got %b exp 0", irq); end
    bus_write(3'd3, 32'h8000_0000);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL fall_unmask_irq got %b exp 1", irq); end
    bus_write(3'd2, 32'h0);
    bus_read(3'd4, v);
    checks++; if (v !== 32'h8000_0000) begin fails++; $display("FAIL disable_keeps_cap got %h exp 80000000", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bus_write(3'd1, '1);
    bus_write(3'd3, '1);
    pins_in = 32'h0000_FF00;
    repeat (D + 2) @(negedge clk);
    reset_n = 1'b0; pins_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checks++; if (filtered_out !== 32'h0 || irq !== 1'b0) begin fails++; $display("FAIL mid_reset cycle %0d filt %h irq %b exp 0/0", n, filtered_out, irq); end
    end
    for (int a = 1; a <= 4; a++) begin
      bus_read(3'(a), v);
      checks++; if (v !== 32'h0) begin fails++; $display("FAIL mid_reset_reg addr %0d got %h exp 0", a, v); end
    end
  endtask

  task automatic test_random();
    int          hold;
    logic [31:0] exp_rd;
    logic        have_exp;
    hold = 0; have_exp = 1'b0; exp_rd = '0;
    reset_n = 1'b0; pins_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int it = 0; it < 800; it++) begin
      if (hold == 0) begin
        pins_in ^= $urandom & $urandom & $urandom;
        hold = int'($urandom_range(1, 8));
      end else begin
        hold--;
      end
      address = 3'($urandom_range(0, 7));
      writedata = $urandom;
      if ($urandom_range(0, 9) < 3) begin
        chipselect = 1'b1; write_n = 1'b0;
        $display("write addr=%0d data=%h", address, writedata);
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
      end
      exp_rd = model_read(address);
      @(negedge clk);
      checks++; if (filtered_out !== m_filt) begin fails++; $display("FAIL rnd_filt it %0d got %h exp %h", it, filtered_out, m_filt); end
      checks++; if (irq !== |(m_cap & m_mask)) begin fails++; $display("FAIL rnd_irq it %0d got %b exp %b", it, irq, |(m_cap & m_mask)); end
      checks++; if (readdata !== exp_rd) begin fails++; $display("FAIL rnd_read it %0d addr %0d got %h exp %h", it, address, readdata, exp_rd); end
      have_exp = 1'b1;
    end
    chipselect = 1'b0; write_n = 1'b1;
    checks++; if (!have_exp) begin fails++; $display("FAIL rnd_no_iterations got 0 exp 1"); end
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; pins_in = '0;
    address0 = '0; cs0 = 1'b0; wn0 = 1'b1; wd0 = '0; pins0 = '0;
    test_reset();
    test_no_debounce();
    test_rise_latency();
    test_clear();
    test_short_pulse();
    test_fall_mask();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, checks %0d failures %0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
